// File: rtl/maxnet_iter_ctrl.sv
// MaxNet iteration controller: issues one PU weight row per cycle, gathers the activated
// results into next_vec, then commits and checks for a single surviving positive neuron.
module maxnet_iter_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*DW-1:0] init_vec,
    input  logic [DW-1:0]   pu_out,
    output logic [N*DW-1:0] a_vec,
    output logic [1:0]      sel,
    output logic            busy,
    output logic            done,
    output logic [1:0]      winner,
    output logic            no_winner,
    output logic            timeout,
    output logic [7:0]      iter_count
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned PW = $clog2(N + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

    state_e                     state_q, state_d;
    logic [N-1:0][DW-1:0]       a_vec_q, a_vec_d;
    logic [N-1:0][DW-1:0]       next_vec_q, next_vec_d;
    logic [1:0]                 sel_q, sel_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [7:0]                 iter_q, iter_d;
    logic [1:0]                 winner_q, winner_d;
    logic                       no_winner_q, no_winner_d;
    logic                       timeout_q, timeout_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [LATENCY-1:0]         pv_q, pv_d;
    logic [LATENCY-1:0][1:0]    pidx_q, pidx_d;
    logic                       push;
    logic [PW-1:0]              pos_cnt;
    logic [1:0]                 first_pos;

    // +0 and -0 are both non-positive
    function automatic logic is_pos(input logic [DW-1:0] w);
        return !w[DW-1] && (|w[DW-2:0]);
    endfunction

    always_comb begin
        state_d     = state_q;
        a_vec_d     = a_vec_q;
        next_vec_d  = next_vec_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        winner_d    = winner_q;
        no_winner_d = no_winner_q;
        timeout_d   = timeout_q;
        push        = 1'b0;
        pos_cnt     = '0;
        first_pos   = '0;

        // Descending scan leaves the lowest positive index in first_pos
        for (int k = N - 1; k >= 0; k--) begin
            if (is_pos(next_vec_q[k])) begin
                pos_cnt   = pos_cnt + 1'b1;
                first_pos = 2'(k);
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_vec_d     = init_vec;
                    iter_d      = '0;
                    timeout_d   = 1'b0;
                    no_winner_d = 1'b0;
                    winner_d    = '0;
                    sel_d       = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                push = 1'b1;
                if (sel_q == 2'(N - 1)) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    sel_d = sel_q + 2'd1;
                end
            end
            StWait: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                a_vec_d = next_vec_q;
                iter_d  = iter_q + 8'd1;
                if (pos_cnt <= PW'(1)) begin
                    state_d     = StDone;
                    winner_d    = first_pos;
                    no_winner_d = (pos_cnt == '0);
                end else if (({1'b0, iter_q} + 9'd1) == 9'(MAX_ITER)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    winner_d  = first_pos;
                end else begin
                    state_d = StIssue;
                    sel_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture pipeline tracks which neuron each in-flight PU result belongs to
        pv_d      = '0;
        pidx_d    = '0;
        pv_d[0]   = push;
        pidx_d[0] = sel_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
        if (pv_q[LATENCY-1]) begin
            next_vec_d[pidx_q[LATENCY-1]] = pu_out;
        end

        busy_d = (state_d == StIssue) || (state_d == StWait) || (state_d == StCheck);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_vec_q     <= '0;
            next_vec_q  <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            iter_q      <= '0;
            winner_q    <= '0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pv_q        <= '0;
            pidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            a_vec_q     <= a_vec_d;
            next_vec_q  <= next_vec_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            iter_q      <= iter_d;
            winner_q    <= winner_d;
            no_winner_q <= no_winner_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
        end
    end

    assign a_vec      = a_vec_q;
    assign sel        = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign winner     = winner_q;
    assign no_winner  = no_winner_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Bench for maxnet_iter_ctrl: scripted PU responses, run-level reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_maxnet_iter_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;
    localparam int unsigned MI  = 3;
    localparam int unsigned PER = N + LAT + 1;
    localparam int unsigned VW  = N * DW;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [VW-1:0] init_vec;
    logic [DW-1:0] pu_out;
    logic [VW-1:0] a_vec;
    logic [1:0]    sel, winner;
    logic          busy, done, no_winner, timeout;
    logic [7:0]    iter_count;

    maxnet_iter_ctrl #(.N(N), .DW(DW), .LATENCY(LAT), .MAX_ITER(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec), .pu_out(pu_out),
        .a_vec(a_vec), .sel(sel), .busy(busy), .done(done), .winner(winner),
        .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Stimulus-side response script and the copy latched by the model at start
    logic [DW-1:0] resp  [0:3][0:N-1];
    logic [DW-1:0] mresp [0:3][0:N-1];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pos(input logic [DW-1:0] w);
        return !w[DW-1] && (w[DW-2:0] != 0);
    endfunction

    function automatic int pos_cnt(input logic [VW-1:0] v);
        int c = 0;
        for (int k = 0; k < N; k++) if (is_pos(v[k*DW +: DW])) c++;
        return c;
    endfunction

    function automatic int low_pos(input logic [VW-1:0] v);
        for (int k = 0; k < N; k++) if (is_pos(v[k*DW +: DW])) return k;
        return 0;
    endfunction

    function automatic logic [VW-1:0] row_s(input int r);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = resp[r][k];
        return v;
    endfunction

    function automatic logic [VW-1:0] row_m(input int r);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = mresp[r][k];
        return v;
    endfunction

    // Number of iterations a run lasts: stop at <=1 positive or at the cap
    function automatic int run_len();
        for (int i = 0; i < int'(MI); i++)
            if (pos_cnt(row_s(i)) <= 1 || i + 1 == int'(MI)) return i + 1;
        return MI;
    endfunction

    // Model: mode 0 idle/reset, 1 running (m_t = cycle number since start), 2 done
    int            mode = 0;
    int            m_t  = 0;
    int            m_k  = 0;
    logic [VW-1:0] m_init;
    logic [1:0]    sel_d1, sel_d2, it_d1, it_d2;

    assign pu_out = mresp[it_d2][sel_d2];

    always @(posedge clk) begin
        sel_d1 <= sel;
        sel_d2 <= sel_d1;
        it_d1  <= (mode == 1) ? 2'((m_t - 1) / int'(PER)) : 2'd0;
        it_d2  <= it_d1;
        if (rst) begin
            mode <= 0;
        end else if (start && mode != 1) begin
            mode   <= 1;
            m_t    <= 1;
            m_k    <= run_len();
            m_init <= init_vec;
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < int'(N); k++) mresp[r][k] <= resp[r][k];
        end else if (mode == 1) begin
            if (m_t == int'(PER) * m_k) mode <= 2;
            else m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int m, ph;
            logic [VW-1:0] fin;
            if (mode == 0) begin
                chk("idle_a_vec", a_vec, '0);
                chk("idle_busy", VW'(busy), '0);
                chk("idle_done", VW'(done), '0);
                chk("idle_iter", VW'(iter_count), '0);
                chk("idle_sel", VW'(sel), '0);
                chk("idle_flags", VW'({winner, no_winner, timeout}), '0);
            end else if (mode == 1) begin
                m  = (m_t - 1) / int'(PER);
                ph = (m_t - 1) % int'(PER);
                chk("run_a_vec", a_vec, (m == 0) ? m_init : row_m(m - 1));
                chk("run_busy", VW'(busy), VW'(1));
                chk("run_done", VW'(done), '0);
                chk("run_iter", VW'(iter_count), VW'(m));
                chk("run_flags", VW'({winner, no_winner, timeout}), '0);
                if (ph < int'(N + LAT))
                    chk("run_sel", VW'(sel), VW'((ph < int'(N)) ? ph : int'(N) - 1));
            end else begin
                fin = row_m(m_k - 1);
                chk("done_a_vec", a_vec, fin);
                chk("done_busy", VW'(busy), '0);
                chk("done_done", VW'(done), VW'(1));
                chk("done_iter", VW'(iter_count), VW'(m_k));
                chk("done_winner", VW'(winner), VW'(low_pos(fin)));
                chk("done_no_winner", VW'(no_winner), VW'(pos_cnt(fin) == 0));
                chk("done_timeout", VW'(timeout), VW'(pos_cnt(fin) > 1));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        resp[r][0] = w0; resp[r][1] = w1; resp[r][2] = w2; resp[r][3] = w3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Count edges until done, optionally poking start while busy; bounded
    task automatic wait_done(input bit poke, output int n);
        n = 0;
        while (!done && n < 200) begin
            start = poke && ($urandom_range(0, 5) == 0);
            tick(1);
            n++;
        end
        start = 1'b0;
        if (!done) chk("wait_done_timeout", VW'(done), VW'(1));
    endtask

    function automatic logic [DW-1:0] rand_word();
        unique case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return {1'b0, 31'($urandom) | 31'h1};
            default: return {1'b1, 31'($urandom)};
        endcase
    endfunction

    initial begin
        int n;
        logic [VW-1:0] expv;
        for (int r = 0; r < 4; r++) for (int k = 0; k < int'(N); k++) resp[r][k] = '0;
        rst = 1'b1; start = 1'b0; init_vec = '0;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(1);

        // Alignment: each index lands in its own slot
        init_vec = {4{32'h3F80_0000}};
        set_row(0, 32'h4000_0000, 32'h4000_0001, 32'h4000_0002, 32'h4000_0003);
        set_row(1, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
        pulse_start();
        tick(7);
        expv = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        chk("align_a_vec", a_vec, expv);
        chk("align_iter", VW'(iter_count), VW'(1));
        chk("align_busy", VW'(busy), VW'(1));
        wait_done(1'b0, n);

        // Convergence after two iterations
        set_row(0, 32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h0);
        set_row(1, 32'h3F4C_CCCD, 32'h0, 32'h0, 32'h0);
        pulse_start();
        wait_done(1'b0, n);
        chk("conv_cycles", VW'(n), VW'(14));
        chk("conv_winner", VW'(winner), VW'(0));
        chk("conv_iter", VW'(iter_count), VW'(2));
        chk("conv_flags", VW'({timeout, no_winner}), VW'(0));

        // -0 and negatives are not positive
        set_row(0, 32'h8000_0000, 32'h0, 32'hBF80_0000, 32'h3E4C_CCCD);
        pulse_start();
        wait_done(1'b0, n);
        chk("neg0_cycles", VW'(n), VW'(7));
        chk("neg0_winner", VW'(winner), VW'(3));
        chk("neg0_no_winner", VW'(no_winner), VW'(0));

        // All zero
        set_row(0, 32'h0, 32'h0, 32'h0, 32'h0);
        pulse_start();
        wait_done(1'b0, n);
        chk("zero_no_winner", VW'(no_winner), VW'(1));
        chk("zero_winner", VW'(winner), VW'(0));
        chk("zero_iter", VW'(iter_count), VW'(1));

        // Timeout at the cap, with ignored start pulses while busy
        for (int r = 0; r < 3; r++)
            set_row(r, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        pulse_start();
        tick(3);
        pulse_start();
        tick(5);
        pulse_start();
        n = 0;
        while (!done && n < 200) begin tick(1); n++; end
        chk("to_cycles", VW'(n + 10), VW'(21));
        chk("to_timeout", VW'(timeout), VW'(1));
        chk("to_iter", VW'(iter_count), VW'(3));

        // Restart from DONE, then reset mid-ISSUE
        pulse_start();
        chk("restart_done", VW'(done), VW'(0));
        chk("restart_iter", VW'(iter_count), VW'(0));
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_a_vec", a_vec, '0);
        chk("rst_iter", VW'(iter_count), VW'(0));
        tick(2);

        // Randomized runs checked by the per-cycle model
        for (int run = 0; run < 40; run++) begin
            for (int k = 0; k < int'(N); k++) init_vec[k*DW +: DW] = rand_word();
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < int'(N); k++) resp[r][k] = rand_word();
            pulse_start();
            wait_done(1'b1, n);
            tick($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxnet_iter_ctrl.md
Name: maxnet_iter_ctrl

Overview:
- Iteration controller that sits directly downstream of the PU and closes the feedback loop of a MaxNet-style winner-take-all network.
- It holds the current activation vector, which drives PU inputs a1..a4, and selects which neuron's weight row is applied.
- It collects the PU's activated outputs, one neuron at a time, into a next-state vector.
- After each full pass it commits that vector and checks for convergence: at most one positive neuron remains, or the iteration cap is reached.

Parameters:
- N, 4, number of neurons; also the number of PU inputs.
- DW, 32, word width (IEEE-754 single).
- LATENCY, 2, clock edges from sel/a_vec being applied to a valid pu_out (PU has a multiplier register plus an adder register).
- MAX_ITER, 255, iteration cap; iter_count width is 8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run with init_vec; sampled only in IDLE or DONE.
- init_vec  in  N*DW  initial activations; neuron k occupies bits [k*DW +: DW].
- pu_out  in  DW  activated PU result.
- a_vec  out  N*DW  current activation vector to PU a1..aN; same packing as init_vec.
- sel  out  2  neuron index whose weight row feeds the PU this cycle.
- busy  out  1  high in ISSUE, WAIT, CHECK.
- done  out  1  high while in DONE.
- winner  out  2  lowest index of a positive neuron in the committed vector.
- no_winner  out  1  committed vector has zero positive neurons.
- timeout  out  1  run ended because MAX_ITER was reached.
- iter_count  out  8  completed iterations in the current run.

Behaviour:
- Reset: state=IDLE; a_vec, next_vec, sel, iter_count, winner = 0; busy, done, no_winner, timeout = 0; capture pipeline valid bits cleared. Reset mid-run abandons the run; no capture occurs after reset.
- "Positive" test on a word: sign bit = 0 and bits[30:0] != 0. Both +0 and -0 count as zero, and so does any negative value.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE or DONE with start=1:
  - a_vec <= init_vec.
  - iter_count, timeout, no_winner, winner <= 0.
  - Go to ISSUE with sel=0. done drops the cycle after start is sampled.
- Start while busy is ignored.
- ISSUE: N cycles with sel = 0, 1, …, N-1; each cycle pushes {valid=1, idx=sel} into a LATENCY-deep capture pipeline. a_vec is held constant for the whole iteration.
- WAIT: LATENCY cycles, sel held at N-1, no new pushes.
- Capture: when the pipeline output is valid, next_vec[idx] <= pu_out. This happens on the edge closing cycle j+LATENCY for the issue in cycle j.
- CHECK: one cycle, evaluated on the fully captured next_vec. At its closing edge:
  - a_vec <= next_vec; iter_count += 1.
  - Count positives P in next_vec.
  - P <= 1: go to DONE; winner = index of the positive neuron (0 if P=0); no_winner = (P==0).
  - Else if iter_count+1 == MAX_ITER: go to DONE; timeout=1; winner = lowest positive index.
  - Else: go back to ISSUE with sel=0.
- Cycles per iteration: N + LATENCY + 1 (7 at defaults). The first ISSUE cycle is the cycle after start is sampled.
- next_vec is not cleared between iterations; every entry is overwritten each pass.
- Outputs in DONE hold until start or rst. All outputs are registered.

Test Plan:
- Reset: assert rst for 2 cycles mid-ISSUE -> next cycle state IDLE, a_vec=0, busy=0, done=0, iter_count=0; no next_vec write on the following 2 edges even though the capture pipeline was non-empty.
- Alignment: init_vec all 0x3F800000; scripted PU model returns 0x40000000+idx, keyed on sel delayed 2 cycles -> after the first CHECK, a_vec word k = 0x40000000+k, iter_count=1, busy still 1.
- Convergence: iteration 1 returns {0x3F800000, 0x3F000000, 0, 0}, iteration 2 returns {0x3F4CCCCD, 0, 0, 0} -> done rises 14 cycles after the start edge; winner=0, iter_count=2, timeout=0, no_winner=0.
- Winner index and -0: iteration 1 returns {0x80000000, 0, 0xBF800000, 0x3E4CCCCD} -> done after 1 iteration, winner=3, no_winner=0.
- All zero: iteration 1 returns all 0 -> done, no_winner=1, winner=0, iter_count=1.
- Timeout, restart and busy: MAX_ITER=3, PU always returns 0x3F800000 -> done after 21 cycles, timeout=1, iter_count=3. Pulse start during the run -> ignored. Pulse start in DONE -> done drops, iter_count=0, new run proceeds.
